local_nic: RTL
==============

# local_nic

Network interface for the local port of a bufferless deflection router. It packetizes core packets into flits driven onto the router's local input, and reassembles the out-of-order flits ejected from the router's local output into whole packets for the core. It sits between the processing element and the router's `dinLocal`/`doutLocal` pair. All-zero flit = empty slot, matching the router's validity rule.

## Interface
- `X_COORD`, 0: this node's X coordinate.
- `Y_COORD`, 0: this node's Y coordinate.
- `PKT_ID_W`, 4: PktId field width.
- `FLIT_ID_W`, 2: FlitId field width. `NUM_FLIT = 2**FLIT_ID_W` flits per packet.
- `TIME_W`, 8: injection timestamp field width.
- `COORD_W`, 3: width of the Xdst and Ydst fields.
- `PAYLOAD_W`, 32: payload bits per flit.
- `SLOTS`, 4: number of reassembly slots.
- Derived: `WIDTH_PORT = PKT_ID_W+FLIT_ID_W+TIME_W+2*COORD_W+PAYLOAD_W`. Flit layout, MSB to LSB: {PktId, FlitId, Time, Xdst, Ydst, payload}.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pkt_in_valid` input 1: core offers a packet.
- `pkt_in_ready` output 1: packet accepted when valid&ready.
- `pkt_in_xdst`, `pkt_in_ydst` input COORD_W: destination coordinates.
- `pkt_in_data` input NUM_FLIT*PAYLOAD_W: flit i carries `[i*PAYLOAD_W +: PAYLOAD_W]`.
- `inj_flit` output WIDTH_PORT: to router `dinLocal`. Registered.
- `ej_flit` input WIDTH_PORT: from router `doutLocal`. Nonzero = valid.
- `pkt_out_valid` output 1: reassembled packet available.
- `pkt_out_ready` input 1: core consumes the packet.
- `pkt_out_data` output NUM_FLIT*PAYLOAD_W: payload, same ordering as `pkt_in_data`.
- `pkt_out_pktid` output PKT_ID_W, `pkt_out_time` output TIME_W: header fields of the delivered packet.
- `err_dup`, `err_overflow`, `err_misroute` output 1 each: sticky error flags.

## Operation
- Timestamp counter `now`:
  - Resets to 1 and increments every cycle.
  - Wraps from 2**TIME_W-1 to 1, never 0. Every injected flit therefore has a nonzero Time field and is never all-zero.
- Injector FSM, states IDLE and SEND:
  - `pkt_in_ready = (state==IDLE)`.
  - On accept: latch data, xdst, ydst, `pid` = PktId counter and `ts` = `now`. Increment the PktId counter (wraps modulo 2**PKT_ID_W). Set flit counter to 0 and go to SEND.
  - In SEND: each cycle register flit {pid, cnt, ts, xdst, ydst, payload[cnt]} into `inj_flit`. After cnt = NUM_FLIT-1, return to IDLE.
  - `inj_flit` = 0 whenever no flit is being driven.
  - There is no backpressure from the router; a flit is never held or repeated.
  - Self-addressed packets are injected normally.
- Ejection and reassembly:
  - Each slot holds valid, key = {PktId, Time}, a NUM_FLIT-bit arrival mask, and the payload buffer. Key uniqueness across sources is a system-level guarantee.
  - A valid `ej_flit` whose Xdst/Ydst ≠ (X_COORD, Y_COORD): drop it and set `err_misroute`.
  - Else, if the key matches a valid slot:
    - mask bit already set: drop and set `err_dup`;
    - otherwise write the payload into that position and set the mask bit.
  - Else, if a free slot exists: allocate the lowest-index free slot, write the flit and set the mask.
  - Else: drop and set `err_overflow`.
  - A slot is complete when its mask is all ones.
- Output register:
  - When empty, or being emptied this cycle by valid&ready, load the lowest-index complete slot and free that slot on the same edge.
  - `pkt_out_*` stay stable while valid&!ready.
  - A freed slot can be reallocated by a flit arriving in the following cycle.
- Error flags clear only on reset.

## Timing
- Reset values:
  - `inj_flit` = 0, `pkt_out_valid` = 0, `pkt_out_data` = 0, `pkt_out_pktid` = 0, `pkt_out_time` = 0, all error flags 0.
  - All slots free, state IDLE, PktId counter 0, `now` = 1.
  - `pkt_in_ready` = 0 while reset is asserted and 1 in the first cycle after release.
- Injection timing:
  - Packet accepted in cycle T: flit k appears on `inj_flit` in cycle T+1+k, so flit NUM_FLIT-1 is at T+NUM_FLIT.
  - `pkt_in_ready` rises at T+NUM_FLIT+1. Maximum rate is one packet per NUM_FLIT+1 cycles.
- Reassembly timing:
  - Last missing flit present on `ej_flit` in cycle T: `pkt_out_valid` = 1 in cycle T+2 if the output register is free, or 1 cycle after the handshake that frees it.
  - Back-to-back deliveries are possible: valid stays high across a handshake when another slot is complete.
- Reset mid-packet aborts the injection and discards all partial reassemblies. No flit is emitted after reset asserts.
- Simultaneous events:
  - A flit allocation and a slot free in the same cycle are independent.
  - A flit cannot hit a slot being freed, because that slot is already complete.

## Test plan
- X_COORD=1, Y_COORD=2; accept a packet with xdst=3, ydst=0, data={D3,D2,D1,D0} at T -> `inj_flit` carries PktId 0, FlitIds 0..3 with payloads D0..D3 in cycles T+1..T+4. All four flits share the same Time. `pkt_in_ready` is 0 during T+1..T+4 and 1 at T+5.
- Hold `pkt_in_valid` continuously for 17 packets -> PktIds 0..15 then 0; no cycle in which `inj_flit` is 0 inside a packet; no flit has Time=0 across a `now` wrap.
- Drive flits 2,0,3,1 of key {5,0x40} to this node -> `pkt_out_valid` 2 cycles after flit 1 arrives, payload correctly ordered, pktid 5, time 0x40.
- Interleave flits of 5 distinct keys with SLOTS=4 and `pkt_out_ready`=0 -> first 4 packets complete, `err_overflow` = 1, fifth key's flits dropped. After 4 handshakes all slots are free.
- Send a repeated FlitId, then a flit with Xdst=0 -> `err_dup` = 1, then `err_misroute` = 1. The slot mask is unchanged by either flit.
- Assert `reset` during SEND and while a slot is partially filled -> `inj_flit` goes to 0 immediately, all outputs are at reset values, and the next packet starts at PktId 0.

Source files
------------

// File: rtl/local_nic_if.sv
// Core/router-facing bundle of the local NIC: packet-in handshake,
// injection/ejection flits, packet-out handshake and sticky error flags.
// Ports (slave = NIC side):
//   in : pkt_in_valid, pkt_in_xdst, pkt_in_ydst, pkt_in_data, ej_flit, pkt_out_ready
//   out: pkt_in_ready, inj_flit, pkt_out_valid, pkt_out_data, pkt_out_pktid,
//        pkt_out_time, err_dup, err_overflow, err_misroute
interface local_nic_if #(
    parameter int PKT_ID_W  = 4,
    parameter int FLIT_ID_W = 2,
    parameter int TIME_W    = 8,
    parameter int COORD_W   = 3,
    parameter int PAYLOAD_W = 32
);
    localparam int NUM_FLIT   = 2 ** FLIT_ID_W;
    localparam int DATA_W     = NUM_FLIT * PAYLOAD_W;
    localparam int WIDTH_PORT = PKT_ID_W + FLIT_ID_W + TIME_W
                              + 2 * COORD_W + PAYLOAD_W;

    logic                  pkt_in_valid;
    logic                  pkt_in_ready;
    logic [COORD_W-1:0]    pkt_in_xdst;
    logic [COORD_W-1:0]    pkt_in_ydst;
    logic [DATA_W-1:0]     pkt_in_data;
    logic [WIDTH_PORT-1:0] inj_flit;
    logic [WIDTH_PORT-1:0] ej_flit;
    logic                  pkt_out_valid;
    logic                  pkt_out_ready;
    logic [DATA_W-1:0]     pkt_out_data;
    logic [PKT_ID_W-1:0]   pkt_out_pktid;
    logic [TIME_W-1:0]     pkt_out_time;
    logic                  err_dup;
    logic                  err_overflow;
    logic                  err_misroute;

    modport master (
        output pkt_in_valid, pkt_in_xdst, pkt_in_ydst, pkt_in_data,
        output ej_flit, pkt_out_ready,
        input  pkt_in_ready, inj_flit, pkt_out_valid, pkt_out_data,
        input  pkt_out_pktid, pkt_out_time,
        input  err_dup, err_overflow, err_misroute
    );

    modport slave (
        input  pkt_in_valid, pkt_in_xdst, pkt_in_ydst, pkt_in_data,
        input  ej_flit, pkt_out_ready,
        output pkt_in_ready, inj_flit, pkt_out_valid, pkt_out_data,
        output pkt_out_pktid, pkt_out_time,
        output err_dup, err_overflow, err_misroute
    );
endinterface

// File: rtl/local_nic.sv
// Local-port NIC for a bufferless deflection router: packetizes core
// packets into flits and reassembles out-of-order ejected flits.
// Ports: clk, reset (async, active-high), bus (local_nic_if.slave):
//   pkt_in_*  -> injector FSM -> inj_flit (registered, 0 = empty slot)
//   ej_flit   -> reassembly slots -> pkt_out_* register
//   err_dup / err_overflow / err_misroute are sticky until reset.
module local_nic #(
    parameter int X_COORD   = 0,
    parameter int Y_COORD   = 0,
    parameter int PKT_ID_W  = 4,
    parameter int FLIT_ID_W = 2,
    parameter int TIME_W    = 8,
    parameter int COORD_W   = 3,
    parameter int PAYLOAD_W = 32,
    parameter int SLOTS     = 4
) (
    input  logic      clk,
    input  logic      reset,
    local_nic_if.slave bus
);
    localparam int NUM_FLIT   = 2 ** FLIT_ID_W;
    localparam int DATA_W     = NUM_FLIT * PAYLOAD_W;
    localparam int WIDTH_PORT = PKT_ID_W + FLIT_ID_W + TIME_W
                              + 2 * COORD_W + PAYLOAD_W;
    localparam int KEY_W      = PKT_ID_W + TIME_W;
    localparam int SIDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int Y_LSB      = PAYLOAD_W;
    localparam int X_LSB      = Y_LSB + COORD_W;
    localparam int T_LSB      = X_LSB + COORD_W;
    localparam int F_LSB      = T_LSB + TIME_W;
    localparam int P_LSB      = F_LSB + FLIT_ID_W;

    typedef enum logic {IDLE, SEND} state_e;

    // ---------------- injector state ----------------
    state_e                state_q, state_d;
    logic [TIME_W-1:0]     now_q, now_d;
    logic [PKT_ID_W-1:0]   pid_ctr_q, pid_ctr_d;
    logic [PKT_ID_W-1:0]   pid_q, pid_d;
    logic [TIME_W-1:0]     ts_q, ts_d;
    logic [COORD_W-1:0]    xdst_q, xdst_d;
    logic [COORD_W-1:0]    ydst_q, ydst_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic [FLIT_ID_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH_PORT-1:0] inj_q, inj_d;
    logic                  accept;

    // ---------------- reassembly state ----------------
    logic [SLOTS-1:0]      slot_vld_q, slot_vld_d;
    logic [KEY_W-1:0]      slot_key_q  [SLOTS];
    logic [KEY_W-1:0]      slot_key_d  [SLOTS];
    logic [NUM_FLIT-1:0]   slot_mask_q [SLOTS];
    logic [NUM_FLIT-1:0]   slot_mask_d [SLOTS];
    logic [DATA_W-1:0]     slot_data_q [SLOTS];
    logic [DATA_W-1:0]     slot_data_d [SLOTS];

    logic                  out_vld_q, out_vld_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [PKT_ID_W-1:0]   out_pid_q, out_pid_d;
    logic [TIME_W-1:0]     out_time_q, out_time_d;
    logic                  err_dup_q, err_dup_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_mis_q, err_mis_d;

    // ---------------- ejected flit fields ----------------
    logic                  ej_vld;
    logic                  ej_here;
    logic [PKT_ID_W-1:0]   ej_pid;
    logic [FLIT_ID_W-1:0]  ej_fid;
    logic [TIME_W-1:0]     ej_time;
    logic [COORD_W-1:0]    ej_x;
    logic [COORD_W-1:0]    ej_y;
    logic [PAYLOAD_W-1:0]  ej_pay;
    logic [KEY_W-1:0]      ej_key;

    logic                  hit, free_ok, done_ok;
    logic [SIDX_W-1:0]     hit_idx, free_idx, done_idx;

    assign ej_vld  = |bus.ej_flit;
    assign ej_pid  = bus.ej_flit[P_LSB +: PKT_ID_W];
    assign ej_fid  = bus.ej_flit[F_LSB +: FLIT_ID_W];
    assign ej_time = bus.ej_flit[T_LSB +: TIME_W];
    assign ej_x    = bus.ej_flit[X_LSB +: COORD_W];
    assign ej_y    = bus.ej_flit[Y_LSB +: COORD_W];
    assign ej_pay  = bus.ej_flit[PAYLOAD_W-1:0];
    assign ej_key  = {ej_pid, ej_time};
    assign ej_here = (ej_x == COORD_W'(X_COORD))
                  && (ej_y == COORD_W'(Y_COORD));

    // Held low during reset so the core never sees an accept then.
    assign bus.pkt_in_ready = (state_q == IDLE) && !reset;
    assign accept           = bus.pkt_in_valid && bus.pkt_in_ready;

    assign bus.inj_flit      = inj_q;
    assign bus.pkt_out_valid = out_vld_q;
    assign bus.pkt_out_data  = out_data_q;
    assign bus.pkt_out_pktid = out_pid_q;
    assign bus.pkt_out_time  = out_time_q;
    assign bus.err_dup       = err_dup_q;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_misroute  = err_mis_q;

    // Timestamp skips 0 so an injected flit is never all-zero.
    always_comb begin
        now_d = (now_q == {TIME_W{1'b1}}) ? TIME_W'(1) : now_q + 1'b1;
    end

    // Injector: flit 0 is registered on the accept edge, the remaining
    // flits follow on consecutive edges; cnt_q tracks the flit on the bus.
    always_comb begin
        state_d   = state_q;
        pid_ctr_d = pid_ctr_q;
        pid_d     = pid_q;
        ts_d      = ts_q;
        xdst_d    = xdst_q;
        ydst_d    = ydst_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        inj_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pid_d     = pid_ctr_q;
                    pid_ctr_d = pid_ctr_q + 1'b1;
                    ts_d      = now_q;
                    xdst_d    = bus.pkt_in_xdst;
                    ydst_d    = bus.pkt_in_ydst;
                    buf_d     = bus.pkt_in_data;
                    cnt_d     = '0;
                    state_d   = SEND;
                    inj_d     = {pid_ctr_q, {FLIT_ID_W{1'b0}}, now_q,
                                 bus.pkt_in_xdst, bus.pkt_in_ydst,
                                 bus.pkt_in_data[PAYLOAD_W-1:0]};
                end
            end
            SEND: begin
                if (cnt_q == {FLIT_ID_W{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    inj_d = {pid_q, cnt_d, ts_q, xdst_q, ydst_q,
                             buf_q[cnt_d*PAYLOAD_W +: PAYLOAD_W]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot lookup: descending scan so the lowest index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        done_ok  = 1'b0;
        done_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_vld_q[i] && (slot_key_q[i] == ej_key)) begin
                hit     = 1'b1;
                hit_idx = SIDX_W'(i);
            end
            if (!slot_vld_q[i]) begin
                free_ok  = 1'b1;
                free_idx = SIDX_W'(i);
            end
            if (slot_vld_q[i] && (&slot_mask_q[i])) begin
                done_ok  = 1'b1;
                done_idx = SIDX_W'(i);
            end
        end
    end

    // Reassembly and output register. Slot freeing uses the registered
    // valid bits, so a slot freed now is only allocatable next cycle.
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_key_d  = slot_key_q;
        slot_mask_d = slot_mask_q;
        slot_data_d = slot_data_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_pid_d   = out_pid_q;
        out_time_d  = out_time_q;
        err_dup_d   = err_dup_q;
        err_ovf_d   = err_ovf_q;
        err_mis_d   = err_mis_q;
        if (ej_vld) begin
            if (!ej_here) begin
                err_mis_d = 1'b1;
            end else if (hit) begin
                if (slot_mask_q[hit_idx][ej_fid]) begin
                    err_dup_d = 1'b1;
                end else begin
                    slot_mask_d[hit_idx][ej_fid] = 1'b1;
                    slot_data_d[hit_idx][ej_fid*PAYLOAD_W +: PAYLOAD_W] = ej_pay;
                end
            end else if (free_ok) begin
                slot_vld_d[free_idx]  = 1'b1;
                slot_key_d[free_idx]  = ej_key;
                slot_mask_d[free_idx] = NUM_FLIT'(1) << ej_fid;
                slot_data_d[free_idx][ej_fid*PAYLOAD_W +: PAYLOAD_W] = ej_pay;
            end else begin
                err_ovf_d = 1'b1;
            end
        end
        if (!out_vld_q || bus.pkt_out_ready) begin
            out_vld_d = done_ok;
            if (done_ok) begin
                out_data_d           = slot_data_q[done_idx];
                out_pid_d            = slot_key_q[done_idx][KEY_W-1 -: PKT_ID_W];
                out_time_d           = slot_key_q[done_idx][TIME_W-1:0];
                slot_vld_d[done_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            now_q      <= TIME_W'(1);
            pid_ctr_q  <= '0;
            pid_q      <= '0;
            ts_q       <= '0;
            xdst_q     <= '0;
            ydst_q     <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            inj_q      <= '0;
            slot_vld_q <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_pid_q  <= '0;
            out_time_q <= '0;
            err_dup_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_mis_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_key_q[i]  <= '0;
                slot_mask_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            now_q      <= now_d;
            pid_ctr_q  <= pid_ctr_d;
            pid_q      <= pid_d;
            ts_q       <= ts_d;
            xdst_q     <= xdst_d;
            ydst_q     <= ydst_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            inj_q      <= inj_d;
            slot_vld_q <= slot_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_pid_q  <= out_pid_d;
            out_time_q <= out_time_d;
            err_dup_q  <= err_dup_d;
            err_ovf_q  <= err_ovf_d;
            err_mis_q  <= err_mis_d;
            for (int i = 0; i < SLOTS; i++) begin
                slot_key_q[i]  <= slot_key_d[i];
                slot_mask_q[i] <= slot_mask_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end
endmodule
